// File: rtl/fir_out_requant.sv
`default_nettype none
// ============================================================================
//  Module   : fir_out_requant
//  Purpose  : FIR output stage - decimate, round/shift, saturate, and buffer
//             samples in a first-word-fall-through FIFO with valid/ready out.
//  Revision : 1.0  initial release
// ============================================================================
module fir_out_requant #(
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 15,
    parameter int DECIM      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic signed [IN_WIDTH-1:0]    in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_WIDTH-1:0]   out_data,
    output logic                          sat_flag,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int c_CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_EXT_W = IN_WIDTH + 1;

    localparam logic signed [c_EXT_W-1:0] c_HALF = c_EXT_W'(1) <<< (SHIFT - 1);
    localparam logic signed [c_EXT_W-1:0] c_MAX  = (c_EXT_W'(1) <<< (OUT_WIDTH - 1)) - c_EXT_W'(1);
    localparam logic signed [c_EXT_W-1:0] c_MIN  = ~c_MAX;
    localparam logic [c_PTR_W:0]          c_FULL = (c_PTR_W + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Decimation phase counter; only valid input cycles advance it.
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;
    logic               w_keep;

    generate
        if (DECIM > 1) begin : g_decim
            always_comb begin
                cnt_d = cnt_q;
                if (in_valid) begin
                    if (cnt_q == c_CNT_W'(DECIM - 1)) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + c_CNT_W'(1);
                    end
                end
            end
        end else begin : g_no_decim
            always_comb begin
                cnt_d = '0;
            end
        end
    endgenerate

    assign w_keep = in_valid && (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: widen by one bit so adding the rounding constant cannot wrap.
    // ------------------------------------------------------------------
    logic signed [c_EXT_W-1:0] w_ext;
    logic signed [c_EXT_W-1:0] w_rnd;
    logic signed [c_EXT_W-1:0] r1_q;
    logic signed [c_EXT_W-1:0] r1_d;
    logic                      v1_q;

    assign w_ext = {in_data[IN_WIDTH-1], in_data};
    assign w_rnd = w_ext + c_HALF;
    assign r1_d  = w_rnd >>> SHIFT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_q <= '0;
            v1_q <= 1'b0;
        end else begin
            v1_q <= w_keep;
            if (w_keep) begin
                r1_q <= r1_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: saturate to the output width.
    // ------------------------------------------------------------------
    logic signed [OUT_WIDTH-1:0] r2_q;
    logic signed [OUT_WIDTH-1:0] r2_d;
    logic                        v2_q;
    logic                        sat_q;
    logic                        w_clip;

    always_comb begin
        r2_d   = r1_q[OUT_WIDTH-1:0];
        w_clip = 1'b0;
        if (r1_q > c_MAX) begin
            r2_d   = c_MAX[OUT_WIDTH-1:0];
            w_clip = 1'b1;
        end else if (r1_q < c_MIN) begin
            r2_d   = c_MIN[OUT_WIDTH-1:0];
            w_clip = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_q  <= '0;
            v2_q  <= 1'b0;
            sat_q <= 1'b0;
        end else begin
            v2_q  <= v1_q;
            sat_q <= v1_q && w_clip;
            if (v1_q) begin
                r2_q <= r2_d;
            end
        end
    end

    assign sat_flag = sat_q;

    // ------------------------------------------------------------------
    // Output FIFO. A push into a full FIFO is still accepted when the
    // head is popped in the same cycle.
    // ------------------------------------------------------------------
    logic signed [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [c_PTR_W-1:0]          wr_ptr_q;
    logic [c_PTR_W-1:0]          rd_ptr_q;
    logic [c_PTR_W:0]            level_q;
    logic [c_PTR_W:0]            level_d;
    logic                        ovf_q;
    logic                        ovf_d;
    logic                        w_empty;
    logic                        w_full;
    logic                        w_pop;
    logic                        w_push;
    logic                        w_drop;

    assign w_empty = (level_q == '0);
    assign w_full  = (level_q == c_FULL);
    assign w_pop   = !w_empty && out_ready;
    assign w_push  = v2_q && (!w_full || w_pop);
    assign w_drop  = v2_q && w_full && !w_pop;

    always_comb begin
        level_d = level_q;
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + (c_PTR_W + 1)'(1);
            2'b01:   level_d = level_q - (c_PTR_W + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (clr_overflow) begin
            ovf_d = 1'b0;
        end
        if (w_drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            level_q <= level_d;
            ovf_q   <= ovf_d;
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: out_data is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= r2_q;
        end
    end

    assign out_valid  = !w_empty;
    assign out_data   = w_empty ? '0 : mem_q[rd_ptr_q];
    assign overflow   = ovf_q;
    assign fifo_level = level_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_out_requant.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_out_requant
//  Purpose  : Self-checking bench for fir_out_requant against a queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fir_out_requant;

    localparam int IN_W  = 32;
    localparam int OUT_W = 16;
    localparam int SH    = 15;
    localparam int DEC   = 2;
    localparam int DEPTH = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic signed [IN_W-1:0]  in_data = '0;
    logic                    out_ready = 1'b0;
    logic                    clr_overflow = 1'b0;
    logic                    out_valid;
    logic signed [OUT_W-1:0] out_data;
    logic                    sat_flag;
    logic                    overflow;
    logic [2:0]              fifo_level;

    always #5 clk = ~clk;

    fir_out_requant #(
        .IN_WIDTH  (IN_W),
        .OUT_WIDTH (OUT_W),
        .SHIFT     (SH),
        .DECIM     (DEC),
        .FIFO_DEPTH(DEPTH)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .sat_flag    (sat_flag),
        .overflow    (overflow),
        .clr_overflow(clr_overflow),
        .fifo_level  (fifo_level)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int due;
        int val;
        bit sat;
    } pend_t;

    longint vcnt;
    int     edge_n;
    pend_t  pend[$];
    int     mfifo[$];
    bit     movf;
    bit     msat;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Round half toward +inf, divide by 2^SH with floor, then clip.
    function automatic int requant(input longint x, output bit sat);
        longint n;
        longint d;
        longint q;
        longint lim;
        d   = 64'sd1 <<< SH;
        n   = x + (d / 2);
        q   = (n >= 0) ? (n / d) : -((-n + d - 1) / d);
        lim = 64'sd1 <<< (OUT_W - 1);
        sat = 1'b0;
        if (q > lim - 1) begin
            q   = lim - 1;
            sat = 1'b1;
        end else if (q < -lim) begin
            q   = -lim;
            sat = 1'b1;
        end
        return int'(q);
    endfunction

    task automatic model_reset();
        vcnt = 0;
        pend.delete();
        mfifo.delete();
        movf = 1'b0;
        msat = 1'b0;
    endtask

    // Advance model and DUT by one clock edge, then compare every output.
    task automatic tick();
        bit    pop;
        bit    full;
        bit    drop;
        bit    s;
        pend_t p;
        full = (mfifo.size() == DEPTH);
        pop  = (mfifo.size() > 0) && out_ready;
        drop = 1'b0;
        edge_n++;
        if (pop) void'(mfifo.pop_front());
        if (pend.size() > 0 && pend[0].due == edge_n) begin
            p = pend.pop_front();
            if (full && !pop) drop = 1'b1;
            else mfifo.push_back(p.val);
        end
        if (clr_overflow) movf = 1'b0;
        if (drop) movf = 1'b1;
        if (in_valid) begin
            if (vcnt % DEC == 0) begin
                p.due = edge_n + 2;
                p.val = requant(longint'(in_data), s);
                p.sat = s;
                pend.push_back(p);
            end
            vcnt++;
        end
        msat = 1'b0;
        foreach (pend[i]) begin
            if (pend[i].due == edge_n + 1 && pend[i].sat) msat = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, (mfifo.size() > 0) ? 1 : 0);
        chk("out_data", out_data, (mfifo.size() > 0) ? mfifo[0] : 0);
        chk("fifo_level", fifo_level, mfifo.size());
        chk("overflow", overflow, movf);
        chk("sat_flag", sat_flag, msat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        longint vals[8];
        int     exps[8];
        bit     sats[8];
        int     got[$];
        int     got2[$];
        int     k;

        vals = '{64'sd3276800, 64'sd16384, -64'sd16384, -64'sd16385, 64'sd16383,
                 64'sd2147483647, -64'sd2147483648, 64'sd1073709056};
        exps = '{100, 1, 0, -1, 0, 32767, -32768, 32767};
        sats = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        model_reset();
        edge_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sat", sat_flag, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_level", fifo_level, 0);
        rst = 1'b0;

        // Directed rounding and saturation, one kept sample plus one dropped.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = IN_W'(vals[i]);
            tick();
            in_data  = $urandom;
            tick();
            in_valid = 1'b0;
            chk("rnd_sat", sat_flag, sats[i]);
            tick();
            chk("rnd_valid", out_valid, 1);
            chk("rnd_data", out_data, exps[i]);
        end
        repeat (3) tick();

        // Randomized traffic with bursts of backpressure.
        for (int i = 0; i < 320; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: in_data = $urandom;
                1: in_data = $signed($urandom) >>> $urandom_range(0, 16);
                2: in_data = ($urandom_range(0, 1) != 0) ? 32'sh7FFFFFFF : 32'sh80000000;
                default: begin
                    k = int'($urandom_range(0, 2000)) - 1000;
                    in_data = k * 16384;
                end
            endcase
            out_ready    = ((i % 64) < 32) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr_overflow = ($urandom_range(0, 15) == 0);
            tick();
        end
        clr_overflow = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        repeat (8) tick();
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;

        // Reset mid-stream: three buffered, one in the pipeline, phase left odd.
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_data  = i * 10 * 32768;
            tick();
            in_data  = 7;
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        chk("pre_rst_level", fifo_level, 3);
        in_valid = 1'b1;
        in_data  = 40 * 32768;
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_level", fifo_level, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Decimation: consecutive valids, then the same values with gaps.
        out_ready = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            in_valid = 1'b1;
            in_data  = j * 32768;
            tick();
            if (out_valid) got.push_back(int'(out_data));
        end
        in_valid = 1'b0;
        repeat (4) begin
            tick();
            if (out_valid) got.push_back(int'(out_data));
        end
        chk("dec_count", got.size(), 4);
        for (int j = 0; j < 4 && j < got.size(); j++) chk("dec_value", got[j], 2 * j + 1);

        for (int j = 1; j <= 8; j++) begin
            in_valid = 1'b1;
            in_data  = j * 32768;
            tick();
            if (out_valid) got2.push_back(int'(out_data));
            in_valid = 1'b0;
            tick();
            if (out_valid) got2.push_back(int'(out_data));
        end
        repeat (4) begin
            tick();
            if (out_valid) got2.push_back(int'(out_data));
        end
        chk("gap_count", got2.size(), 4);
        for (int j = 0; j < 4 && j < got2.size(); j++) chk("gap_value", got2[j], 2 * j + 1);

        // Overflow: six kept samples into a four-entry FIFO with no consumer.
        out_ready = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            in_valid = 1'b1;
            in_data  = j * 32768;
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("ovf_level", fifo_level, 4);
        chk("ovf_flag", overflow, 1);
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("ovf_drain", out_data, 2 * j + 1);
            tick();
        end
        chk("ovf_sticky", overflow, 1);
        chk("ovf_empty", fifo_level, 0);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // Full FIFO with a push and a pop on the same edge.
        out_ready = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            in_valid = 1'b1;
            in_data  = (50 + j) * 32768;
            tick();
            in_data  = 3;
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        chk("full_level", fifo_level, 4);
        in_valid = 1'b1;
        in_data  = 77 * 32768;
        tick();
        in_data  = 5;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("pushpop_level", fifo_level, 4);
        chk("pushpop_ovf", overflow, 0);
        chk("pushpop_head", out_data, 52);
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
